// File: rtl/intbus_arb_pkg.sv
// Shared types and constants for the intbus arbiter.
package intbus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } arb_state_e;

  // Wide enough for any practical DATA_WIDTH; users take the low slice.
  localparam int MAX_DATA_W = 256;
  localparam logic [MAX_DATA_W-1:0] ERR_RDATA = '1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intbus_interf.sv
// Shared downstream bus: one master issues rd/wr strobes, the slave answers reads with rvalid/rdata.
interface intbus_interf #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 32
) ();

  logic                  clk;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rd;
  logic                  wr;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output clk, addr, wdata, rd, wr, input rvalid, rdata);
  modport slave  (input clk, addr, wdata, rd, wr, output rvalid, rdata);

endinterface

// File: rtl/intbus_arbiter_rr.sv
// Combinational round-robin picker: searches from last_grant+1 (mod N) for the first active request.
module rr_arbiter
  import intbus_arb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int IDX_W     = idx_width(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]     last_grant_i,
  output logic [N_MASTERS-1:0] grant_o,
  output logic [IDX_W-1:0]     grant_idx_o,
  output logic                 grant_vld_o
);

  int cand;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    cand        = 0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      cand = (int'(last_grant_i) + k) % N_MASTERS;
      if (!grant_vld_o && req_i[cand]) begin
        grant_vld_o   = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/intbus_arbiter.sv
// Round-robin arbiter serialising N requesters onto one intbus master port.
// Optional read timeout is enabled by defining INTBUS_ARB_TIMEOUT_EN.
module intbus_arbiter
  import intbus_arb_pkg::*;
#(
  parameter int N_MASTERS  = 2,
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_MASTERS-1:0]             req,
  input  logic [N_MASTERS-1:0]             req_wr,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]  req_wdata,
  output logic [N_MASTERS-1:0]             ack,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  intbus_interf.master                     m_bus
);

  localparam int IDX_W = idx_width(N_MASTERS);

  arb_state_e            state_q;
  logic [IDX_W-1:0]      last_grant_q;
  logic [N_MASTERS-1:0]  grant_q;
  logic [N_MASTERS-1:0]  ack_q;
  logic                  is_wr_q;
  logic                  bus_rd_q;
  logic                  bus_wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [N_MASTERS-1:0]  grant_d;
  logic [IDX_W-1:0]      grant_idx_d;
  logic                  grant_vld_d;

`ifdef INTBUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             err_q;
`endif

  rr_arbiter #(
    .N_MASTERS (N_MASTERS),
    .IDX_W     (IDX_W)
  ) u_rr (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .grant_o      (grant_d),
    .grant_idx_o  (grant_idx_d),
    .grant_vld_o  (grant_vld_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(N_MASTERS - 1);
      grant_q      <= '0;
      ack_q        <= '0;
      is_wr_q      <= 1'b0;
      bus_rd_q     <= 1'b0;
      bus_wr_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
`ifdef INTBUS_ARB_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      // Strobes and ack are single-cycle pulses unless re-asserted below.
      bus_rd_q <= 1'b0;
      bus_wr_q <= 1'b0;
      ack_q    <= '0;
      case (state_q)
        IDLE: begin
          if (grant_vld_d) begin
            last_grant_q <= grant_idx_d;
            grant_q      <= grant_d;
            is_wr_q      <= req_wr[grant_idx_d];
            bus_wr_q     <= req_wr[grant_idx_d];
            bus_rd_q     <= ~req_wr[grant_idx_d];
            addr_q       <= req_addr[grant_idx_d*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_q      <= req_wdata[grant_idx_d*DATA_WIDTH +: DATA_WIDTH];
`ifdef INTBUS_ARB_TIMEOUT_EN
            err_q        <= 1'b0;
`endif
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          if (is_wr_q) begin
            rdata_q <= '0;
            ack_q   <= grant_q;
            state_q <= DONE;
          end else if (m_bus.rvalid) begin
            rdata_q <= m_bus.rdata;
            ack_q   <= grant_q;
            state_q <= DONE;
          end else begin
`ifdef INTBUS_ARB_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
            state_q <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (m_bus.rvalid) begin
            rdata_q <= m_bus.rdata;
            ack_q   <= grant_q;
            state_q <= DONE;
          end
`ifdef INTBUS_ARB_TIMEOUT_EN
          // The cycle the counter reads TIMEOUT-1 is the last WAIT_RD cycle.
          else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
            rdata_q <= ERR_RDATA[DATA_WIDTH-1:0];
            err_q   <= 1'b1;
            ack_q   <= grant_q;
            state_q <= DONE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_bus.clk   = clk;
  assign m_bus.addr  = addr_q;
  assign m_bus.wdata = wdata_q;
  assign m_bus.rd    = bus_rd_q;
  assign m_bus.wr    = bus_wr_q;
  assign ack         = ack_q;
  assign rsp_rdata   = rdata_q;
`ifdef INTBUS_ARB_TIMEOUT_EN
  assign rsp_err     = err_q;
`else
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_intbus_arbiter.sv
// Self-checking bench for intbus_arbiter: vector table, multi-cycle corner sequences, random traffic vs. a reference model.
module tb_intbus_arbiter;

  localparam int N  = 2;
  localparam int AW = 28;
  localparam int DW = 32;
  localparam int TO = 15;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    req_wr;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;

  logic            slv_comb;
  logic            slv_rv;
  logic [DW-1:0]   slv_data;

  int total = 0;
  int bad   = 0;
  int last_m;

  intbus_interf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  assign bus.rvalid = (slv_comb & bus.rd) | slv_rv;
  assign bus.rdata  = slv_data;

  intbus_arbiter #(
    .N_MASTERS  (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .m_bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Spec rule: first active requester after the previous winner, wrapping modulo N.
  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // Expected ack latency counted from the IDLE cycle that samples req.
  function automatic int exp_latency(input bit wr, input int dly);
    if (wr || dly == 0) return 2;
    if (dly <= TO) return 2 + dly;
    return 2 + TO;
  endfunction

  // One transaction starting in an IDLE cycle; dly: 0 = combinational rvalid, k = rvalid k cycles after rd.
  task automatic run_txn(input string nm, input logic [1:0] rv, input logic [1:0] wrv,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic [DW-1:0] rdat, input int dly, input int exp_w,
                         input logic [DW-1:0] exp_rd, input logic exp_err, input int exp_lat);
    int n;
    bit seen;
    bit bus_ok;
    int pulses;
    logic [N-1:0]  ack_s;
    logic [DW-1:0] rd_s;
    logic          err_s;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    bit            ewr;
    ea = (exp_w == 1) ? a1 : a0;
    ed = (exp_w == 1) ? d1 : d0;
    ewr = wrv[exp_w];
    req = rv; req_wr = wrv; req_addr = {a1, a0}; req_wdata = {d1, d0};
    slv_comb = 1'b0; slv_rv = 1'b1; slv_data = $urandom;
    n = 0; seen = 0; bus_ok = 1; pulses = 0;
    ack_s = '0; rd_s = '0; err_s = 1'b0;
    while (!seen && n < 40) begin
      step();
      n++;
      if (bus.rd && bus.wr) bus_ok = 0;
      if (bus.rd || bus.wr) begin
        pulses++;
        if (n != 1 || bus.wr !== ewr || bus.addr !== ea || bus.wdata !== ed) bus_ok = 0;
      end
      if (ack !== '0) begin
        seen = 1; ack_s = ack; rd_s = rsp_rdata; err_s = rsp_err;
      end
      slv_rv = 1'b0;
      slv_data = $urandom;
      slv_comb = 1'b0;
      if (!ewr && dly == 0 && n == 1) begin
        slv_comb = 1'b1; slv_data = rdat;
      end
      if (!ewr && dly > 0 && n == 1 + dly) begin
        slv_rv = 1'b1; slv_data = rdat;
      end
    end
    check($sformatf("%s.acked", nm), 64'(seen), 64'd1);
    check($sformatf("%s.ack", nm), 64'(ack_s), 64'(2'b01 << exp_w));
    check($sformatf("%s.latency", nm), 64'(n), 64'(exp_lat));
    check($sformatf("%s.rdata", nm), 64'(rd_s), 64'(exp_rd));
    check($sformatf("%s.err", nm), 64'(err_s), 64'(exp_err));
    check($sformatf("%s.strobe", nm), 64'({bus_ok, pulses[7:0]}), 64'({1'b1, 8'd1}));
    // Drop req in the ack cycle and push stray rvalid at the arbiter while it is not listening.
    req = '0; slv_comb = 1'b0; slv_rv = 1'b1; slv_data = $urandom;
    step();
    check($sformatf("%s.hold", nm), 64'({ack, rsp_rdata}), 64'({2'b00, exp_rd}));
    slv_rv = 1'b0;
    last_m = exp_w;
  endtask

  typedef struct {
    logic [1:0]    rv;
    logic [1:0]    wrv;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1, rdat;
    int            dly;
    int            exp_w;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
    int            exp_lat;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [N-1:0] acks [$];
    int           ack_t [$];
    bit           ovl;
    tbl[0] = '{2'b10, 2'b10, 28'h0, 28'h10, 32'h0, 32'hA5A5A5A5, 32'h0, 0, 1, 32'h0, 1'b0, 2};
    tbl[1] = '{2'b01, 2'b00, 28'h20, 28'h0, 32'h0, 32'h0, 32'h12345678, 0, 0, 32'h12345678, 1'b0, 2};
    tbl[2] = '{2'b10, 2'b00, 28'h0, 28'hABCDEF, 32'h0, 32'h0, 32'hDEADBEEF, 5, 1, 32'hDEADBEEF, 1'b0, 7};
    tbl[3] = '{2'b01, 2'b01, 28'h44, 28'h0, 32'h0BADF00D, 32'h0, 32'h0, 0, 0, 32'h0, 1'b0, 2};
    tbl[4] = '{2'b11, 2'b01, 28'h50, 28'h60, 32'h11, 32'h22, 32'hCAFEF00D, 2, 1, 32'hCAFEF00D, 1'b0, 4};
    tbl[5] = '{2'b11, 2'b11, 28'h70, 28'h80, 32'h33, 32'h44, 32'h0, 0, 0, 32'h0, 1'b0, 2};
    tbl[6] = '{2'b11, 2'b00, 28'h90, 28'hA0, 32'h55, 32'h66, 32'h00000001, 1, 1, 32'h00000001, 1'b0, 3};

    rst = 1'b1; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    slv_comb = 1'b0; slv_rv = 1'b0; slv_data = '0;
    repeat (3) step();
    check("reset.outs", 64'({ack, rsp_rdata, rsp_err}), 64'(0));
    check("reset.bus", 64'({bus.rd, bus.wr, bus.addr}), 64'(0));
    check("reset.wdata", 64'(bus.wdata), 64'(0));
    rst = 1'b0;
    last_m = N - 1;

    // Both requesters held high continuously: back-to-back writes rotate 0,1,0,1.
    req = 2'b11; req_wr = 2'b11; req_addr = {28'h200, 28'h100}; req_wdata = {32'hB, 32'hA};
    ovl = 0;
    for (int n = 1; n <= 11; n++) begin
      step();
      if (bus.rd && bus.wr) ovl = 1;
      if (ack !== '0) begin
        acks.push_back(ack);
        ack_t.push_back(n);
      end
      if (n == 11) req = '0;
    end
    step();
    check("rot.count", 64'(acks.size()), 64'd4);
    check("rot.overlap", 64'(ovl), 64'd0);
    for (int i = 0; i < acks.size() && i < 4; i++) begin
      check($sformatf("rot.ack%0d", i), 64'(acks[i]), 64'(2'b01 << (i % 2)));
      check($sformatf("rot.time%0d", i), 64'(ack_t[i]), 64'(2 + 3 * i));
    end
    last_m = 1;

    for (int i = 0; i < 7; i++)
      run_txn($sformatf("vec%0d", i), tbl[i].rv, tbl[i].wrv, tbl[i].a0, tbl[i].a1,
              tbl[i].d0, tbl[i].d1, tbl[i].rdat, tbl[i].dly, tbl[i].exp_w,
              tbl[i].exp_rd, tbl[i].exp_err, tbl[i].exp_lat);

    // Reset while stuck in WAIT_RD: everything drops at once, requester 0 wins afterwards.
    req = 2'b10; req_wr = 2'b00; req_addr = {28'h3C0, 28'h0}; slv_rv = 1'b0; slv_comb = 1'b0;
    repeat (4) step();
    check("rstmid.pending", 64'(ack), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("rstmid.immediate", 64'({bus.rd, bus.wr, ack, rsp_err}), 64'd0);
    req = 2'b11;
    step();
    check("rstmid.held", 64'({bus.rd, bus.wr, ack}), 64'd0);
    rst = 1'b0;
    last_m = N - 1;
    run_txn("rstmid.first", 2'b11, 2'b11, 28'h5, 28'h6, 32'h7, 32'h8, 32'h0, 0, 0, 32'h0, 1'b0, 2);

`ifdef INTBUS_ARB_TIMEOUT_EN
    run_txn("timeout", 2'b01, 2'b00, 28'hF00, 28'h0, 32'h0, 32'h0, 32'h0, 99, 0,
            32'hFFFFFFFF, 1'b1, 2 + TO);
`endif

    for (int t = 0; t < 30; t++) begin
      logic [1:0]    rv;
      logic [1:0]    wrv;
      logic [DW-1:0] rdat;
      int            dly;
      int            w;
      rv   = 2'($urandom_range(1, 3));
      wrv  = 2'($urandom_range(0, 3));
      rdat = $urandom;
      dly  = $urandom_range(0, 8);
      w    = rr_pick(rv, last_m);
      run_txn($sformatf("rnd%0d", t), rv, wrv, AW'($urandom), AW'($urandom), $urandom, $urandom,
              rdat, dly, w, wrv[w] ? 32'h0 : rdat, 1'b0, exp_latency(wrv[w], dly));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/intbus_arbiter.md
INTBUS_ARBITER -- requirements
Module: intbus_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 2, number of requesters (1..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 28, bus address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, bus data width.
REQ-004 SHALL have parameter TIMEOUT, default 15, maximum cycles to wait for rvalid after a read.
REQ-005 SHALL use one clock and an asynchronous, active-high reset; all sequential logic SHALL be in the clk domain.
REQ-006 SHALL have port clk  input  1  bus clock.
REQ-007 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-008 SHALL have port req  input  N_MASTERS  per-requester level request, held until ack.
REQ-009 SHALL have port req_wr  input  N_MASTERS  1 = write, 0 = read.
REQ-010 SHALL have port req_addr  input  N_MASTERS*ADDR_WIDTH  packed addresses, requester i at slice i.
REQ-011 SHALL have port req_wdata  input  N_MASTERS*DATA_WIDTH  packed write data.
REQ-012 SHALL have port ack  output  N_MASTERS  one-cycle completion pulse to the granted requester.
REQ-013 SHALL have port rsp_rdata  output  DATA_WIDTH  read data, valid in the ack cycle.
REQ-014 SHALL have port rsp_err  output  1  timeout flag, valid in the ack cycle.
REQ-015 SHALL have port m_bus  intbus_interf.master  --  shared downstream bus; m_bus.clk SHALL be driven from clk.

Function
REQ-016 SHALL implement an FSM with states IDLE, ISSUE, WAIT_RD, DONE.
REQ-017 In IDLE with any req high, SHALL grant round-robin starting at last_grant+1 (mod N_MASTERS), latch addr/wdata/wr of the winner, and go to ISSUE.
REQ-018 In ISSUE, SHALL drive m_bus.addr/wdata from the latch and assert exactly one of m_bus.wr or m_bus.rd for exactly one cycle.
REQ-019 A write in ISSUE SHALL go to DONE; a read SHALL go to DONE if m_bus.rvalid is high in the same cycle, else to WAIT_RD.
REQ-020 In WAIT_RD, SHALL go to DONE on rvalid, capturing m_bus.rdata into rsp_rdata.
REQ-021 In DONE, SHALL assert ack for the granted index for one cycle, then return to IDLE.
REQ-022 Latency: write ack, and read ack when rvalid is combinational, occur 2 cycles after the IDLE cycle sampling req.
REQ-023 m_bus.rd and m_bus.wr SHALL never be high together; m_bus.rd and m_bus.wr SHALL be 0 outside ISSUE.
REQ-024 rsp_rdata SHALL hold its value until the next capture; it SHALL be 0 for writes.
REQ-025 rvalid outside ISSUE/WAIT_RD SHALL be ignored.
REQ-026 A requester SHALL drop req in the cycle after ack; req still high in IDLE SHALL count as a new request.
REQ-027 With a single requester continuously requesting, it SHALL be granted every transaction; with all requesting, grants SHALL rotate 0,1,...,N-1,0.

Reset
REQ-028 On rst: state IDLE, last_grant = N_MASTERS-1 (requester 0 first), ack/rsp_rdata/rsp_err/m_bus.addr/wdata/rd/wr = 0, timeout counter = 0.
REQ-029 Reset mid-transaction SHALL abort it immediately with no ack issued.

Configuration
REQ-030 With INTBUS_ARB_TIMEOUT_EN defined, WAIT_RD SHALL count cycles and, on reaching TIMEOUT without rvalid, SHALL go to DONE with rsp_err=1 and rsp_rdata=all-ones; rsp_err SHALL otherwise be 0.
REQ-031 Without INTBUS_ARB_TIMEOUT_EN, WAIT_RD SHALL wait indefinitely, rsp_err SHALL be tied 0, and no counter SHALL be built.

Structure
REQ-032 Package intbus_arb_pkg SHALL hold the state enum and the ERR_RDATA constant (all-ones).
REQ-033 Round-robin grant SHALL be a sub-module rr_arbiter (req vector, last_grant in -> one-hot grant and index out).

Verification
REQ-034 Write from requester 1 only, addr 0x10, wdata 0xA5A5A5A5 -> m_bus.wr for 1 cycle with that addr/data; ack=2'b10 two cycles after the req sample; rsp_err=0.
REQ-035 Read from requester 0, combinational slave returns rvalid+0x12345678 with rd -> ack=2'b01 2 cycles later, rsp_rdata=0x12345678.
REQ-036 Both requesters held high for 4 transactions -> grant order 0,1,0,1; no overlap of rd/wr.
REQ-037 Read where rvalid arrives 5 cycles after rd -> ack in the cycle after rvalid, correct rdata.
REQ-038 With INTBUS_ARB_TIMEOUT_EN, read with no rvalid -> ack after TIMEOUT=15 WAIT_RD cycles, rsp_err=1, rsp_rdata=0xFFFFFFFF.
REQ-039 rst asserted during WAIT_RD -> rd/wr/ack 0 immediately, IDLE, requester 0 granted first after release.
